alu_muldiv_unit: RTL and testbench

ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

---
 rtl/alu_muldiv_unit_if.sv | 36 +++
 rtl/alu_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit_if
// Request/response bundle for alu_muldiv_unit.
//   master : requester side (drives in_valid/op/i1/i2/flush/out_ready)
//   slave  : the unit (drives in_ready/out_valid/o/illegal_op)
// Signals:
//   in_valid   request present           in_ready   unit accepts request
//   op[4:0]    operation code            i1, i2     operands (WIDTH bits)
//   flush      abandon operation         out_valid  result available
//   out_ready  consumer takes result     o          result (WIDTH bits)
//   illegal_op op code was undefined
// -----------------------------------------------------------------------------
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             illegal_op;

  modport master (
    output in_valid, op, i1, i2, flush, out_ready,
    input  in_ready, out_valid, o, illegal_op
  );

  modport slave (
    input  in_valid, op, i1, i2, flush, out_ready,
    output in_ready, out_valid, o, illegal_op
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit
// Integer ALU with iterative multiply/divide behind a valid/ready handshake.
// Single-pass ops finish one cycle after accept; MUL*/DIV*/REM* run WIDTH
// shift-add or restoring-divide steps and finish WIDTH+1 cycles after accept.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      alu_muldiv_unit_if.slave (request, response, flush)
// -----------------------------------------------------------------------------
module alu_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_OR     = 5'd2;
  localparam logic [4:0] OP_AND    = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_PASS   = 5'd10;
  localparam logic [4:0] OP_JALR   = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_REM    = 5'd22;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  // Control state
  state_t           r_state;
  state_t           w_state_nx;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_o;
  logic             r_illegal;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_is_iter;

  // Iterative datapath
  logic [2:0]       r_iop;      // op[2:0] of the captured iterative op
  logic [WIDTH-1:0] r_a;        // raw i1, needed for REM by zero
  logic [WIDTH-1:0] r_mcand;    // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] r_hi;       // product high / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier bits / dividend bits -> quotient
  logic             r_neg_q;    // negate product or quotient at the end
  logic             r_neg_r;    // negate remainder at the end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign w_is_iter = (bus.op[4:3] == 2'b10);
  assign w_accept  = bus.in_valid & w_in_ready & ~bus.flush;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nx  = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nx = w_is_iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (r_cnt == CNT_LAST) w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Flush wins over accept and over the output handshake.
    if (bus.flush) w_state_nx = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.o          = r_o;
  assign bus.illegal_op = r_illegal;

  // ---------------------------------------------------------------------------
  // Single-pass ALU, evaluated on the live inputs in the accept cycle
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum_ab;
  logic [WIDTH-1:0] w_base_res;
  logic             w_base_ill;

  assign w_shamt  = bus.i2[SHW-1:0];
  assign w_sum_ab = bus.i1 + bus.i2;

  always_comb begin
    w_base_res = '0;
    w_base_ill = 1'b0;
    case (bus.op)
      OP_ADD:  w_base_res = w_sum_ab;
      OP_SUB:  w_base_res = bus.i1 - bus.i2;
      OP_OR:   w_base_res = bus.i1 | bus.i2;
      OP_AND:  w_base_res = bus.i1 & bus.i2;
      OP_XOR:  w_base_res = bus.i1 ^ bus.i2;
      OP_SLL:  w_base_res = bus.i1 << w_shamt;
      OP_SRL:  w_base_res = bus.i1 >> w_shamt;
      OP_SRA:  w_base_res = WIDTH'($signed(bus.i1) >>> w_shamt);
      OP_SLT:  w_base_res = {{(WIDTH-1){1'b0}}, ($signed(bus.i1) < $signed(bus.i2))};
      OP_SLTU: w_base_res = {{(WIDTH-1){1'b0}}, (bus.i1 < bus.i2)};
      OP_PASS: w_base_res = bus.i2;
      OP_JALR: w_base_res = w_sum_ab & {{(WIDTH-2){1'b1}}, 2'b00};
      default: w_base_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand preparation: the core iterates on magnitudes, signs are restored
  // once at the end.
  // ---------------------------------------------------------------------------
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_sgn_a = (bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                   (bus.op == OP_DIV)  | (bus.op == OP_REM);
  assign w_sgn_b = (bus.op == OP_MULH) | (bus.op == OP_DIV) | (bus.op == OP_REM);
  assign w_neg_a = w_sgn_a & bus.i1[WIDTH-1];
  assign w_neg_b = w_sgn_b & bus.i2[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.i1 : bus.i1;
  assign w_mag_b = w_neg_b ? -bus.i2 : bus.i2;

  // ---------------------------------------------------------------------------
  // One iteration step (shift-add multiply or restoring divide)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});
  assign w_sub   = w_shift - {1'b0, r_mcand};

  always_comb begin
    if (r_iop[2]) begin
      // Remainder stays below the divisor, so the top bit is always dropped.
      w_hi_nx = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      {w_hi_nx, w_lo_nx} = {w_sum, r_lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final result from the last step's values, committed on BUSY->DONE
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div0;
  logic [WIDTH-1:0]   w_iter_res;

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nx : w_lo_nx;
  assign w_rem    = r_neg_r ? -w_hi_nx : w_hi_nx;
  assign w_div0   = (r_mcand == '0);

  // Most-negative / -1 needs no special case: the magnitude quotient wraps back
  // to the most-negative value and the remainder is zero.
  always_comb begin
    w_iter_res = '0;
    case (r_iop)
      3'd0:       w_iter_res = w_prod_s[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       w_iter_res = w_prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: w_iter_res = w_div0 ? '1  : w_quo;
      3'd6, 3'd7: w_iter_res = w_div0 ? r_a : w_rem;
      default:    w_iter_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_o       <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_BUSY && w_state_nx == S_BUSY) ? r_cnt + 1'b1 : '0;
      if (w_accept && !w_is_iter) begin
        r_o       <= w_base_res;
        r_illegal <= w_base_ill;
      end else if (r_state == S_BUSY && w_state_nx == S_DONE) begin
        r_o       <= w_iter_res;
        r_illegal <= 1'b0;
      end
    end
  end

  // NOTE: the iteration registers have no reset; they are fully loaded at
  // every accept and nothing observes them outside BUSY.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_iter) begin
      r_iop   <= bus.op[2:0];
      r_a     <= bus.i1;
      r_hi    <= '0;
      r_mcand <= bus.op[2] ? w_mag_b : w_mag_a;
      r_lo    <= bus.op[2] ? w_mag_a : w_mag_b;
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end else if (r_state == S_BUSY) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_unit
// Directed bench for alu_muldiv_unit (WIDTH=32): hand-computed vectors for the
// corner cases, then random legal ops against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  alu_muldiv_unit_if #(.WIDTH(W)) bus ();

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; after the accepting edge, scramble the
  // inputs to show they were captured.
  task automatic issue(input logic [4:0] f_op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = f_op;
    bus.i1       = a;
    bus.i2       = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 5'(($urandom % 12));
    bus.i1       = $urandom;
    bus.i2       = $urandom;
  endtask

  // Cycles from accept to out_valid (1 = visible right after the accept edge).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [4:0] f_op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_o, input logic exp_ill, input int exp_lat,
                       input int stall, input string tag);
    int lat;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    issue(f_op, a, b);
    wait_valid(lat);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".o"}, 64'(bus.o), 64'(exp_o));
    check({tag, ".illegal_op"}, 64'(bus.illegal_op), 64'(exp_ill));
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] f_op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] pu;
    longint      ps;
    int          sa;
    int          sb;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f_op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a | b;
      5'd3:  return a & b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return {31'b0, sa < sb};
      5'd9:  return {31'b0, a < b};
      5'd10: return b;
      5'd11: return (a + b) & 32'hFFFF_FFFC;
      5'd16: return a * b;
      5'd17: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      5'd18: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      5'd19: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  logic [4:0] legal_ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
                                 5'd22, 5'd23};

  initial begin
    int          lat;
    logic        saw_valid;
    logic [4:0]  r_op;
    logic [31:0] ra;
    logic [31:0] rb;

    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.i1        = '0;
    bus.i2        = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready",   64'(bus.in_ready),   64'd1);
    check("rst.out_valid",  64'(bus.out_valid),  64'd0);
    check("rst.o",          64'(bus.o),          64'd0);
    check("rst.illegal_op", 64'(bus.illegal_op), 64'd0);

    // Single-pass corner vectors
    do_op(5'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0, "add_wrap");
    do_op(5'd7, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1, 0, "sra");
    do_op(5'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 0, "slt");
    do_op(5'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0, "sltu");
    do_op(5'd11, 32'h1000_0001, 32'h6,        32'h1000_0004, 1'b0, 1, 0, "jalr");

    // Multiply corners
    do_op(5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 0, "mulh");
    do_op(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 0, "mulhsu");

    // Divide corners
    do_op(5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 33, 0, "div_neg");
    do_op(5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 33, 0, "rem_neg");
    do_op(5'd21, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b0, 33, 0, "divu_by0");
    do_op(5'd23, 32'h5,         32'h0,         32'h5,         1'b0, 33, 0, "remu_by0");
    do_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 0, "div_ovf");
    do_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33, 0, "rem_ovf");

    // Output held while the consumer stalls
    issue(5'd0, 32'd10, 32'd20);
    wait_valid(lat);
    check("stall.latency", 64'(lat), 64'd1);
    repeat (10) begin
      check("stall.o",         64'(bus.o),         64'd30);
      check("stall.out_valid", 64'(bus.out_valid), 64'd1);
      check("stall.in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("stall.release_valid", 64'(bus.out_valid), 64'd0);
    check("stall.release_ready", 64'(bus.in_ready),  64'd1);

    // Flush at BUSY cycle 12 discards the multiply
    issue(5'd16, 32'd3, 32'd4);
    repeat (11) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush.in_ready", 64'(bus.in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("flush.no_valid", 64'(saw_valid), 64'd0);
    do_op(5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0, "after_flush");

    // A request coinciding with flush is dropped
    bus.in_valid = 1'b1;
    bus.op       = 5'd0;
    bus.i1       = 32'd7;
    bus.i2       = 32'd8;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_req.out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_req.in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    check("flush_req.still_idle", 64'(bus.out_valid), 64'd0);

    // Undefined op code
    do_op(5'd31, 32'h1234, 32'h5678, 32'h0, 1'b1, 1, 0, "illegal31");
    do_op(5'd1, 32'd9, 32'd4, 32'd5, 1'b0, 1, 0, "legal_after");

    // Reset in the middle of a divide
    issue(5'd20, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst.out_valid",  64'(bus.out_valid),  64'd0);
    check("midrst.in_ready",   64'(bus.in_ready),   64'd1);
    check("midrst.o",          64'(bus.o),          64'd0);
    check("midrst.illegal_op", 64'(bus.illegal_op), 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("midrst.no_valid", 64'(saw_valid), 64'd0);

    // Random legal ops, back-to-back, with consumer stalls
    for (int k = 0; k < 40; k++) begin
      r_op = legal_ops[$urandom_range(0, 19)];
      ra   = (k % 5 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb   = (k % 8 == 0) ? 32'h0 : ((k % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      do_op(r_op, ra, rb, ref_model(r_op, ra, rb), 1'b0, (r_op >= 5'd16) ? 33 : 1,
            int'($urandom_range(0, 3)), $sformatf("rand%0d_op%0d", k, r_op));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
